// File: rtl/counter_run_controller.sv
// Run controller for an up/down counter with prescaler, pause/hold, one-shot
// completion and auto-reload. Configuration is captured when a run starts.
module counter_run_controller #(
   parameter int WIDTH = 4,
   parameter int DIV   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             dir_up,
   input  logic             reload,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             wrap,
   output logic [1:0]       state
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, HOLD = 2'b10, DONE = 2'b11} state_t;

   state_t           st, st_nx;
   logic [WIDTH-1:0] q_nx, load_r, load_nx, limit_r, limit_nx;
   logic             dir_r, dir_nx, reload_r, reload_nx, wrap_nx;
   logic [PW-1:0]    pre, pre_nx;
   logic             tick;

   assign tick = (pre == PW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= IDLE;
         q        <= '0;
         pre      <= '0;
         load_r   <= '0;
         limit_r  <= '0;
         dir_r    <= 1'b0;
         reload_r <= 1'b0;
         wrap     <= 1'b0;
      end else begin
         st       <= st_nx;
         q        <= q_nx;
         pre      <= pre_nx;
         load_r   <= load_nx;
         limit_r  <= limit_nx;
         dir_r    <= dir_nx;
         reload_r <= reload_nx;
         wrap     <= wrap_nx;
      end
   end

   always_comb begin
      st_nx     = st;
      q_nx      = q;
      pre_nx    = pre;
      load_nx   = load_r;
      limit_nx  = limit_r;
      dir_nx    = dir_r;
      reload_nx = reload_r;
      wrap_nx   = 1'b0;
      if (stop) begin
         st_nx  = IDLE;
         q_nx   = '0;
         pre_nx = '0;
      end else begin
         case (st)
            IDLE: if (start) begin
               st_nx     = RUN;
               q_nx      = load_val;
               pre_nx    = '0;
               load_nx   = load_val;
               limit_nx  = limit;
               dir_nx    = dir_up;
               reload_nx = reload;
            end
            RUN: begin
               // pause wins over a pending tick: no step in the cycle we enter HOLD
               if (pause) begin
                  st_nx = HOLD;
               end else if (tick) begin
                  pre_nx = '0;
                  if (q != limit_r) begin
                     q_nx = dir_r ? q + 1'b1 : q - 1'b1;
                  end else if (reload_r) begin
                     q_nx    = load_r;
                     wrap_nx = 1'b1;
                  end else begin
                     st_nx = DONE;
                  end
               end else begin
                  pre_nx = pre + 1'b1;
               end
            end
            HOLD: if (!pause) st_nx = RUN;
            DONE: st_nx = IDLE;
            default: st_nx = IDLE;
         endcase
      end
   end

   assign state = st;
   assign busy  = (st == RUN) || (st == HOLD);
   assign done  = (st == DONE);

endmodule
